// File: rtl/instr_fetch_unit_pkg.sv
// Shared constants for the instruction fetch unit: instruction fields,
// the reset NOP, fetch FSM state encoding and opcodes used by checks.
package instr_fetch_unit_pkg;

    localparam int unsigned INSTR_OPCODE_WIDTH = 7;
    localparam logic [31:0] INSTR_NOP          = 32'h0000_0013;

    // Fetch FSM state encoding (2 bits).
    localparam logic [1:0] FETCH_STATE_IDLE  = 2'd0;
    localparam logic [1:0] FETCH_STATE_WAIT  = 2'd1;
    localparam logic [1:0] FETCH_STATE_FAULT = 2'd2;

    // Opcodes referenced when checking opCode.
    localparam logic [6:0] OPCODE_OP     = 7'b0110011;
    localparam logic [6:0] OPCODE_OP_IMM = 7'b0010011;

endpackage

// File: rtl/instr_fetch_unit_pc_register.sv
// Program counter with a single pending-update slot. Updates requested while a
// fetch is outstanding are parked and applied when the fetch ends, so the
// request address never moves mid-transaction.
module pc_register #(
    parameter int unsigned     XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            pcWrite,
    input  logic [XLEN-1:0] pcNext,
    input  logic            defer,   // a fetch is outstanding
    input  logic            commit,  // the outstanding fetch ends at this edge
    output logic [XLEN-1:0] pc,
    output logic            pcMisaligned
);

    logic [XLEN-1:0] pending;
    logic            pendingValid;
    logic [XLEN-1:0] aligned;

    assign aligned = {pcNext[XLEN-1:2], 2'b00};

    // pc, pending slot and sticky misalign flag
    always_ff @(posedge clk) begin
        if (rst) begin
            pc           <= RESET_PC;
            pending      <= '0;
            pendingValid <= 1'b0;
            pcMisaligned <= 1'b0;
        end else begin
            if (pcWrite && (pcNext[1:0] != 2'b00)) begin
                pcMisaligned <= 1'b1;
            end
            if (defer) begin
                if (commit) begin
                    // A write on the closing edge is newer than anything parked.
                    if (pcWrite) begin
                        pc <= aligned;
                    end else if (pendingValid) begin
                        pc <= pending;
                    end
                    pendingValid <= 1'b0;
                end else if (pcWrite) begin
                    pending      <= aligned;
                    pendingValid <= 1'b1;
                end
            end else if (pcWrite) begin
                pc <= aligned;
            end
        end
    end

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch front end: owns the IR and the instruction-memory request/ready
// handshake, with a timeout that parks the unit in FAULT until reset.
module instr_fetch_unit
    import instr_fetch_unit_pkg::*;
#(
    parameter int unsigned     XLEN           = 32,
    parameter logic [XLEN-1:0] RESET_PC       = 32'h0000_0000,
    parameter int unsigned     TIMEOUT_CYCLES = 15
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            IRWrite,
    input  logic            PCWrite,
    input  logic [XLEN-1:0] pcNext,
    input  logic [31:0]     imemRdata,
    input  logic            imemReady,
    output logic            imemReq,
    output logic [XLEN-1:0] imemAddr,
    output logic [XLEN-1:0] pc,
    output logic [31:0]     instr,
    output logic [6:0]      opCode,
    output logic            fetchBusy,
    output logic            fetchFault,
    output logic            pcMisaligned
);

    localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT_CYCLES - 1);

    logic [1:0] state;
    logic [7:0] count;
    logic       inWait;
    logic       waitDone;
    logic       timedOut;

    assign inWait   = (state == FETCH_STATE_WAIT);
    assign timedOut = inWait && !imemReady && (count == TIMEOUT_LAST);
    // Any exit from WAIT releases the parked pc update.
    assign waitDone = inWait && (imemReady || timedOut);

    assign opCode    = instr[INSTR_OPCODE_WIDTH-1:0];
    assign fetchBusy = inWait;

    pc_register #(
        .XLEN     (XLEN),
        .RESET_PC (RESET_PC)
    ) u_pc_register (
        .clk          (clk),
        .rst          (rst),
        .pcWrite      (PCWrite),
        .pcNext       (pcNext),
        .defer        (inWait),
        .commit       (waitDone),
        .pc           (pc),
        .pcMisaligned (pcMisaligned)
    );

    // Fetch FSM, request/address registers, IR and timeout counter
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= FETCH_STATE_IDLE;
            count      <= 8'd0;
            imemReq    <= 1'b0;
            imemAddr   <= RESET_PC;
            instr      <= INSTR_NOP;
            fetchFault <= 1'b0;
        end else begin
            case (state)
                FETCH_STATE_IDLE: begin
                    if (IRWrite) begin
                        state    <= FETCH_STATE_WAIT;
                        imemReq  <= 1'b1;
                        imemAddr <= pc;
                        count    <= 8'd0;
                    end
                end
                FETCH_STATE_WAIT: begin
                    if (imemReady) begin
                        instr   <= imemRdata;
                        imemReq <= 1'b0;
                        state   <= FETCH_STATE_IDLE;
                    end else if (timedOut) begin
                        instr      <= INSTR_NOP;
                        imemReq    <= 1'b0;
                        fetchFault <= 1'b1;
                        state      <= FETCH_STATE_FAULT;
                    end else begin
                        count <= count + 8'd1;
                    end
                end
                FETCH_STATE_FAULT: begin
                    // Held until reset.
                end
                default: begin
                    state   <= FETCH_STATE_IDLE;
                    imemReq <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: handshake latency, deferred pc updates,
// timeout fault, alignment flag, simultaneous IRWrite/PCWrite and mid-fetch reset.
module tb_instr_fetch_unit;
    import instr_fetch_unit_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        IRWrite;
    logic        PCWrite;
    logic [31:0] pcNext;
    logic [31:0] imemRdata;
    logic        imemReady;
    logic        imemReq;
    logic [31:0] imemAddr;
    logic [31:0] pc;
    logic [31:0] instr;
    logic [6:0]  opCode;
    logic        fetchBusy;
    logic        fetchFault;
    logic        pcMisaligned;

    int compared   = 0;
    int mismatched = 0;

    instr_fetch_unit #(
        .XLEN           (32),
        .RESET_PC       (32'h0000_0000),
        .TIMEOUT_CYCLES (15)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .IRWrite      (IRWrite),
        .PCWrite      (PCWrite),
        .pcNext       (pcNext),
        .imemRdata    (imemRdata),
        .imemReady    (imemReady),
        .imemReq      (imemReq),
        .imemAddr     (imemAddr),
        .pc           (pc),
        .instr        (instr),
        .opCode       (opCode),
        .fetchBusy    (fetchBusy),
        .fetchFault   (fetchFault),
        .pcMisaligned (pcMisaligned)
    );

    always #5 clk = ~clk;

    // Advance one edge; inputs change and outputs are sampled 1 time unit later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        rst = 1'b1; IRWrite = 1'b0; PCWrite = 1'b0; pcNext = '0;
        imemRdata = '0; imemReady = 1'b0;
        tick(); tick();
        rst = 1'b0;

        // Reset state
        check("rst_pc", pc, 32'h0);
        check("rst_instr", instr, 32'h0000_0013);
        check("rst_opcode", {25'd0, opCode}, {25'd0, OPCODE_OP_IMM});
        check("rst_req", {31'd0, imemReq}, 32'd0);
        check("rst_addr", imemAddr, 32'h0);
        check("rst_busy", {31'd0, fetchBusy}, 32'd0);
        check("rst_fault", {31'd0, fetchFault}, 32'd0);
        check("rst_mis", {31'd0, pcMisaligned}, 32'd0);

        // Fastest fetch: ready in the first WAIT cycle
        IRWrite = 1'b1; tick(); IRWrite = 1'b0;
        check("f1_req", {31'd0, imemReq}, 32'd1);
        check("f1_addr", imemAddr, 32'h0);
        check("f1_busy", {31'd0, fetchBusy}, 32'd1);
        check("f1_instr_not_yet", instr, 32'h0000_0013);
        imemReady = 1'b1; imemRdata = 32'h0020_8133; tick(); imemReady = 1'b0;
        check("f1_instr", instr, 32'h0020_8133);
        check("f1_opcode", {25'd0, opCode}, {25'd0, OPCODE_OP});
        check("f1_busy_off", {31'd0, fetchBusy}, 32'd0);
        check("f1_req_off", {31'd0, imemReq}, 32'd0);

        // Delayed ready with a deferred PCWrite in the 2nd WAIT cycle
        IRWrite = 1'b1; tick(); IRWrite = 1'b0;          // WAIT cycle 1
        tick();                                           // WAIT cycle 2
        PCWrite = 1'b1; pcNext = 32'h0000_0040; tick(); PCWrite = 1'b0;  // cycle 3
        check("f2_pc_deferred", pc, 32'h0);
        check("f2_addr_hold3", imemAddr, 32'h0);
        tick(); tick();                                   // WAIT cycle 5
        check("f2_addr_hold5", imemAddr, 32'h0);
        check("f2_req_hold5", {31'd0, imemReq}, 32'd1);
        check("f2_pc_still", pc, 32'h0);
        imemReady = 1'b1; imemRdata = 32'h0010_0093; tick(); imemReady = 1'b0;
        check("f2_pc_applied", pc, 32'h0000_0040);
        check("f2_instr", instr, 32'h0010_0093);
        check("f2_busy_off", {31'd0, fetchBusy}, 32'd0);

        // Timeout: memory never answers
        IRWrite = 1'b1; tick(); IRWrite = 1'b0;           // WAIT cycle 1
        check("to_addr", imemAddr, 32'h0000_0040);
        for (int i = 0; i < 14; i++) tick();              // WAIT cycle 15
        check("to_req_c15", {31'd0, imemReq}, 32'd1);
        check("to_fault_c15", {31'd0, fetchFault}, 32'd0);
        tick();
        check("to_req_drop", {31'd0, imemReq}, 32'd0);
        check("to_fault", {31'd0, fetchFault}, 32'd1);
        check("to_instr_nop", instr, 32'h0000_0013);
        check("to_busy", {31'd0, fetchBusy}, 32'd0);
        IRWrite = 1'b1; tick(); IRWrite = 1'b0;
        check("to_irwrite_ignored", {31'd0, imemReq}, 32'd0);
        check("to_busy_ignored", {31'd0, fetchBusy}, 32'd0);
        PCWrite = 1'b1; pcNext = 32'h0000_0080; tick(); PCWrite = 1'b0;
        check("to_pc_write", pc, 32'h0000_0080);
        imemReady = 1'b1; imemRdata = 32'h1234_5678; tick(); imemReady = 1'b0;
        check("to_ready_ignored", instr, 32'h0000_0013);
        rst = 1'b1; tick(); rst = 1'b0;
        check("to_rst_fault", {31'd0, fetchFault}, 32'd0);
        check("to_rst_pc", pc, 32'h0);

        // Misaligned PCWrite, flag is sticky
        PCWrite = 1'b1; pcNext = 32'h0000_0106; tick();
        check("mis_pc", pc, 32'h0000_0104);
        check("mis_flag", {31'd0, pcMisaligned}, 32'd1);
        pcNext = 32'h0000_0200; tick(); PCWrite = 1'b0;
        check("mis_pc2", pc, 32'h0000_0200);
        check("mis_sticky", {31'd0, pcMisaligned}, 32'd1);

        // Wrap-around address is legal
        PCWrite = 1'b1; pcNext = 32'hFFFF_FFFC; tick();
        check("wrap_pc", pc, 32'hFFFF_FFFC);

        // IRWrite and PCWrite on the same edge
        pcNext = 32'h0000_0004; tick();
        check("same_pre_pc", pc, 32'h0000_0004);
        IRWrite = 1'b1; pcNext = 32'h0000_0008; tick(); IRWrite = 1'b0; PCWrite = 1'b0;
        check("same_addr", imemAddr, 32'h0000_0004);
        check("same_pc", pc, 32'h0000_0008);
        check("same_req", {31'd0, imemReq}, 32'd1);
        imemReady = 1'b1; imemRdata = 32'h0000_0033; tick(); imemReady = 1'b0;
        check("same_instr", instr, 32'h0000_0033);
        check("same_pc_after", pc, 32'h0000_0008);

        // Reset in the 3rd WAIT cycle, then a late ready
        IRWrite = 1'b1; tick(); IRWrite = 1'b0;           // WAIT cycle 1
        tick(); tick();                                   // WAIT cycle 3
        check("mid_req_before", {31'd0, imemReq}, 32'd1);
        rst = 1'b1; tick(); rst = 1'b0;
        check("mid_req", {31'd0, imemReq}, 32'd0);
        check("mid_busy", {31'd0, fetchBusy}, 32'd0);
        check("mid_pc", pc, 32'h0);
        check("mid_instr", instr, 32'h0000_0013);
        check("mid_mis_clr", {31'd0, pcMisaligned}, 32'd0);
        check("mid_addr", imemAddr, 32'h0);
        imemReady = 1'b1; imemRdata = 32'hDEAD_BEEF; tick(); imemReady = 1'b0;
        check("mid_late_ready", instr, 32'h0000_0013);
        check("mid_late_req", {31'd0, imemReq}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
- Front end of the multi-cycle core; sits directly upstream of the main controller.
- Holds the PC and the instruction register (IR), and runs the instruction-memory request/ready handshake when the controller pulses IRWrite.
- Applies PC updates on PCWrite.
- Drives opCode to the controller and reports busy/fault status so the controller can stall in FETCH.

Parameters:
XLEN, 32, datapath/address width
RESET_PC, 32'h0000_0000, PC value after reset
TIMEOUT_CYCLES, 15, max cycles waiting for imemReady before fault (1..255)

Ports:
clk  input  1  core clock, all state updates on rising edge
rst  input  1  synchronous, active-high reset
IRWrite  input  1  controller request: fetch instruction at current pc into IR
PCWrite  input  1  controller request: load pc from pcNext
pcNext  input  XLEN  next PC from ALU result
imemRdata  input  32  instruction memory read data, valid when imemReady=1
imemReady  input  1  instruction memory completion strobe
imemReq  output  1  registered read request to instruction memory
imemAddr  output  XLEN  registered read address, stable while imemReq=1
pc  output  XLEN  current program counter
instr  output  32  instruction register contents
opCode  output  7  instr[6:0], combinational from IR
fetchBusy  output  1  high while a fetch is outstanding
fetchFault  output  1  sticky: memory timeout occurred
pcMisaligned  output  1  sticky: PCWrite with pcNext[1:0]!=0

Behaviour:
- Reset (rst=1 at an edge, regardless of state, including mid-fetch):
  - State = IDLE; pc = RESET_PC; instr = 32'h0000_0013 (NOP, so opCode = 7'b0010011).
  - imemReq = 0; imemAddr = RESET_PC; fetchBusy = 0; fetchFault = 0; pcMisaligned = 0.
  - Pending-PC register is cleared; timeout counter = 0.
- FSM states: IDLE, WAIT, FAULT.
- IDLE:
  - IRWrite=1 at edge t → in cycle t+1: state=WAIT, imemReq=1, imemAddr=pc (sampled at t), fetchBusy=1, counter=0.
- WAIT:
  - imemReady=1 at an edge → instr <= imemRdata, imemReq <= 0, state <= IDLE, fetchBusy <= 0. New opCode is visible the cycle after ready.
  - Minimum latency IRWrite→instr valid: 2 cycles (ready in the first WAIT cycle).
  - imemReady=0 → counter increments. When counter reaches TIMEOUT_CYCLES-1 with still no ready: state <= FAULT, imemReq <= 0, fetchFault <= 1, instr <= NOP.
  - imemReady while in IDLE or FAULT is ignored.
- FAULT:
  - Only rst exits. IRWrite is ignored; fetchBusy = 0; pc still updates on PCWrite.
- PCWrite:
  - In IDLE: pc <= {pcNext[XLEN-1:2], 2'b00} at the same edge.
  - If pcNext[1:0]!=0: pcMisaligned <= 1 (sticky); the aligned value is still loaded.
  - In WAIT: the update is deferred. pcNext is captured in the pending register and applied at the completion edge, so imemAddr never changes during a request. A second PCWrite in WAIT overwrites the pending value (last wins).
- IRWrite and PCWrite at the same edge in IDLE: the fetch uses the old pc, and pc takes the new value at the same edge (matches controller FETCH→DECODE ordering).
- IRWrite while in WAIT: ignored, no queueing.
- pc arithmetic is modulo 2^XLEN: pcNext=FFFF_FFFC is legal, and the next +4 wraps to 0. This block does not add 4 itself.
- Counter width: 8 bits.

Decomposition:
- instr_defines.h: INSTR_OPCODE_WIDTH (7), INSTR_NOP (32'h0000_0013).
- New fetch_state_defines.h: FETCH_STATE_IDLE/WAIT/FAULT, 2-bit encoding.
- opcode_defines.h is reused by the bench for opCode checks.
- One sub-module: pc_register. It holds pc plus the pending-PC value and valid bit, and performs alignment and the misalign flag. The FSM, IR and counter stay in instr_fetch_unit.

Test Plan:
- Reset, then IRWrite pulse; memory returns ready in the first WAIT cycle with rdata=32'h0020_8133 → imemAddr=0 while imemReq=1; instr=32'h0020_8133 2 cycles after IRWrite; opCode=7'b0110011; fetchBusy high for exactly 1 cycle.
- IRWrite with ready delayed 5 cycles, and PCWrite pcNext=32'h0000_0040 in the 2nd WAIT cycle → imemAddr holds 0 throughout; pc=0x40 only after the completion edge.
- Memory never ready, TIMEOUT_CYCLES=15 → imemReq drops and fetchFault=1 after 15 WAIT cycles; instr=NOP; subsequent IRWrite is ignored; rst clears the fault and pc=0.
- PCWrite pcNext=32'h0000_0106 in IDLE → pc=0x104, pcMisaligned=1 and stays 1 after a later aligned PCWrite.
- IRWrite and PCWrite (pcNext=0x8) at the same edge from pc=0x4 → imemAddr=0x4, pc=0x8.
- rst asserted in the 3rd WAIT cycle, then ready arrives → state IDLE, imemReq=0, instr remains NOP (late ready ignored), pc=RESET_PC.
